// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared state encoding, player codes and helpers for the game.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int PAT_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PICK = 3'd1,
        S_REVEAL    = 3'd2,
        S_MOVE      = 3'd3,
        S_CHECK     = 3'd4,
        S_NEXT      = 3'd5,
        S_OVER      = 3'd6
    } state_t;

    typedef logic [1:0] player_t;

    localparam player_t P_NONE = 2'd0;
    localparam player_t P1     = 2'd1;
    localparam player_t P2     = 2'd2;
    localparam player_t P3     = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'd15;

    // Rotate 1..num, wrapping back to player 1 after the last active player.
    function automatic player_t next_player(input player_t p, input int num);
        return (p == player_t'(num)) ? P1 : player_t'(p + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/turn_controller_if.sv
// ============================================================================
// Module   : turn_controller_if
// Purpose  : Game-control bundle between the sequencer and its surroundings.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface turn_controller_if #(
    parameter int PAT_W = 4
);
    logic             start;
    logic             pick_valid;
    logic [PAT_W-1:0] card_pattern;
    logic [PAT_W-1:0] tile_pattern;
    logic             W;
    logic [1:0]       T;
    logic             B;
    logic             reveal;
    logic             match;
    logic [3:0]       streak;
    logic             game_over;
    logic [1:0]       winner;

    modport master (
        output start, pick_valid, card_pattern, tile_pattern, W,
        input  T, B, reveal, match, streak, game_over, winner
    );

    modport slave (
        input  start, pick_valid, card_pattern, tile_pattern, W,
        output T, B, reveal, match, streak, game_over, winner
    );
endinterface

`default_nettype wire

// File: rtl/reveal_timer.sv
// ============================================================================
// Module   : reveal_timer
// Purpose  : Loadable down-counter with zero flag; holds at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reveal_timer #(
    parameter int WIDTH = 26
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/turn_controller.sv
// ============================================================================
// Module   : turn_controller
// Purpose  : Turn sequencer: reveals picks, pulses moves, rotates turns, detects wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module turn_controller
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS   = 3,
    parameter int PAT_W         = PAT_W_DEFAULT,
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int TIMER_W       = 26
) (
    input  wire logic        clk,
    input  wire logic        rst,
    turn_controller_if.slave bus
);

    localparam logic [TIMER_W-1:0] c_reload = TIMER_W'(REVEAL_CYCLES - 1);

    state_t          r_state;
    player_t         r_t;
    logic            r_b;
    logic            r_reveal;
    logic            r_match;
    logic [3:0]      r_streak;
    logic            r_game_over;
    player_t         r_winner;

    state_t          w_state_nxt;
    player_t         w_t_nxt;
    logic            w_b_nxt;
    logic            w_reveal_nxt;
    logic            w_match_nxt;
    logic [3:0]      w_streak_nxt;
    logic            w_game_over_nxt;
    player_t         w_winner_nxt;
    logic            w_tmr_load;
    logic            w_tmr_zero;
    logic [PAT_W-1:0] w_card;
    logic [PAT_W-1:0] w_tile;

    assign w_card = bus.card_pattern;
    assign w_tile = bus.tile_pattern;

    reveal_timer #(
        .WIDTH (TIMER_W)
    ) u_reveal_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (c_reload),
        .i_dec      (r_state == S_REVEAL),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_t         <= P_NONE;
            r_b         <= 1'b0;
            r_reveal    <= 1'b0;
            r_match     <= 1'b0;
            r_streak    <= 4'd0;
            r_game_over <= 1'b0;
            r_winner    <= P_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_b         <= w_b_nxt;
            r_reveal    <= w_reveal_nxt;
            r_match     <= w_match_nxt;
            r_streak    <= w_streak_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    // Each register is updated on the edge that enters the state owning it,
    // so B and the turn change both land REVEAL_CYCLES+1 cycles after a pick.
    always_comb begin
        w_state_nxt     = r_state;
        w_t_nxt         = r_t;
        w_b_nxt         = 1'b0;
        w_reveal_nxt    = r_reveal;
        w_match_nxt     = r_match;
        w_streak_nxt    = r_streak;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;
        w_tmr_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_t_nxt      = P1;
                    w_streak_nxt = 4'd0;
                    w_state_nxt  = S_WAIT_PICK;
                end
            end
            S_WAIT_PICK: begin
                if (bus.pick_valid) begin
                    w_match_nxt  = (w_card == w_tile);
                    w_tmr_load   = 1'b1;
                    w_reveal_nxt = 1'b1;
                    w_state_nxt  = S_REVEAL;
                end
            end
            S_REVEAL: begin
                if (w_tmr_zero) begin
                    w_reveal_nxt = 1'b0;
                    if (r_match) begin
                        w_b_nxt      = 1'b1;
                        w_streak_nxt = (r_streak == STREAK_MAX) ? STREAK_MAX
                                                                : r_streak + 4'd1;
                        w_state_nxt  = S_MOVE;
                    end else begin
                        w_t_nxt      = next_player(r_t, NUM_PLAYERS);
                        w_streak_nxt = 4'd0;
                        w_state_nxt  = S_NEXT;
                    end
                end
            end
            S_MOVE: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // W reflects the position update triggered by the preceding B pulse.
                if (bus.W) begin
                    w_winner_nxt    = r_t;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_OVER;
                end else begin
                    w_state_nxt = S_WAIT_PICK;
                end
            end
            S_NEXT: begin
                w_state_nxt = S_WAIT_PICK;
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.T         = r_t;
    assign bus.B         = r_b;
    assign bus.reveal    = r_reveal;
    assign bus.match     = r_match;
    assign bus.streak    = r_streak;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_turn_controller.sv
// ============================================================================
// Module   : tb_turn_controller
// Purpose  : Directed self-checking bench for turn_controller (3- and 2-player).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_turn_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    turn_controller_if #(.PAT_W(4)) bus_a ();
    turn_controller_if #(.PAT_W(4)) bus_b ();

    turn_controller #(
        .NUM_PLAYERS   (3),
        .PAT_W         (4),
        .REVEAL_CYCLES (4),
        .TIMER_W       (26)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    turn_controller #(
        .NUM_PLAYERS   (2),
        .PAT_W         (4),
        .REVEAL_CYCLES (4),
        .TIMER_W       (26)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one pick on DUT A and watch the following 8 cycles.
    task automatic run_pick(input logic [3:0] card, input logic [3:0] tile, input bit inject,
                            output int rev_cnt, output int b_at, output int b_cnt,
                            output int t_at);
        logic [1:0] t0;
        t0      = bus_a.T;
        rev_cnt = 0;
        b_at    = -1;
        b_cnt   = 0;
        t_at    = -1;
        bus_a.pick_valid   = 1'b1;
        bus_a.card_pattern = card;
        bus_a.tile_pattern = tile;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus_a.pick_valid = inject && (k == 2);
            if (bus_a.reveal) rev_cnt++;
            if (bus_a.B) begin
                b_cnt++;
                if (b_at < 0) b_at = k;
            end
            if ((t_at < 0) && (bus_a.T != t0)) t_at = k;
        end
    endtask

    task automatic pick_b(input logic [3:0] card, input logic [3:0] tile);
        bus_b.pick_valid   = 1'b1;
        bus_b.card_pattern = card;
        bus_b.tile_pattern = tile;
        tick();
        bus_b.pick_valid = 1'b0;
        repeat (7) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv, ba, bc, ta;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.pick_valid = 1'b0; bus_a.W = 1'b0;
        bus_a.card_pattern = 4'd0; bus_a.tile_pattern = 4'd0;
        bus_b.start = 1'b0; bus_b.pick_valid = 1'b0; bus_b.W = 1'b0;
        bus_b.card_pattern = 4'd0; bus_b.tile_pattern = 4'd0;
        #3;
        chk("rst_T",         32'(bus_a.T), 0);
        chk("rst_B",         32'(bus_a.B), 0);
        chk("rst_reveal",    32'(bus_a.reveal), 0);
        chk("rst_match",     32'(bus_a.match), 0);
        chk("rst_streak",    32'(bus_a.streak), 0);
        chk("rst_game_over", 32'(bus_a.game_over), 0);
        chk("rst_winner",    32'(bus_a.winner), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_T", 32'(bus_a.T), 0);

        // start and pick together in IDLE: only start acts, pick is not queued
        bus_a.start = 1'b1; bus_a.pick_valid = 1'b1;
        bus_a.card_pattern = 4'd5; bus_a.tile_pattern = 4'd5;
        tick();
        bus_a.start = 1'b0; bus_a.pick_valid = 1'b0;
        chk("start_T",      32'(bus_a.T), 1);
        chk("start_B",      32'(bus_a.B), 0);
        chk("start_reveal", 32'(bus_a.reveal), 0);
        tick(); tick();
        chk("start_nopick", 32'(bus_a.reveal), 0);
        chk("start_go",     32'(bus_a.game_over), 0);

        // match path
        run_pick(4'd5, 4'd5, 1'b0, rv, ba, bc, ta);
        chk("match_reveal_cycles", 32'(rv), 4);
        chk("match_b_at",          32'(ba), 5);
        chk("match_b_count",       32'(bc), 1);
        chk("match_T",             32'(bus_a.T), 1);
        chk("match_streak",        32'(bus_a.streak), 1);

        // match with a stray pick during REVEAL
        run_pick(4'd7, 4'd7, 1'b1, rv, ba, bc, ta);
        chk("inject_reveal_cycles", 32'(rv), 4);
        chk("inject_b_at",          32'(ba), 5);
        chk("inject_b_count",       32'(bc), 1);
        chk("inject_streak",        32'(bus_a.streak), 2);

        // mismatch path and wrap 1,2,3,1
        run_pick(4'd5, 4'd3, 1'b0, rv, ba, bc, ta);
        chk("mis_b_count", 32'(bc), 0);
        chk("mis_t_at",    32'(ta), 5);
        chk("mis_T",       32'(bus_a.T), 2);
        chk("mis_streak",  32'(bus_a.streak), 0);
        run_pick(4'd1, 4'd2, 1'b0, rv, ba, bc, ta);
        chk("wrap_T3", 32'(bus_a.T), 3);
        run_pick(4'd1, 4'd2, 1'b0, rv, ba, bc, ta);
        chk("wrap_T1", 32'(bus_a.T), 1);

        // win by player 2
        run_pick(4'd9, 4'd8, 1'b0, rv, ba, bc, ta);
        chk("win_pre_T", 32'(bus_a.T), 2);
        bus_a.W = 1'b1;
        run_pick(4'd6, 4'd6, 1'b0, rv, ba, bc, ta);
        chk("win_b_count",   32'(bc), 1);
        chk("win_game_over", 32'(bus_a.game_over), 1);
        chk("win_winner",    32'(bus_a.winner), 2);
        chk("win_streak",    32'(bus_a.streak), 1);

        // OVER ignores start and pick
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        run_pick(4'd6, 4'd6, 1'b0, rv, ba, bc, ta);
        chk("over_reveal",    32'(rv), 0);
        chk("over_b_count",   32'(bc), 0);
        chk("over_T",         32'(bus_a.T), 2);
        chk("over_winner",    32'(bus_a.winner), 2);
        chk("over_game_over", 32'(bus_a.game_over), 1);

        // two-player wrap 1,2,1
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        chk("np2_T1", 32'(bus_b.T), 1);
        pick_b(4'd1, 4'd2);
        chk("np2_T2", 32'(bus_b.T), 2);
        pick_b(4'd1, 4'd2);
        chk("np2_T1_wrap", 32'(bus_b.T), 1);

        // asynchronous reset in the middle of a reveal
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.W = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.pick_valid = 1'b1; bus_a.card_pattern = 4'd4; bus_a.tile_pattern = 4'd4;
        tick();
        bus_a.pick_valid = 1'b0;
        tick();
        chk("arst_pre_reveal", 32'(bus_a.reveal), 1);
        chk("arst_pre_match",  32'(bus_a.match), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_T",         32'(bus_a.T), 0);
        chk("arst_reveal",    32'(bus_a.reveal), 0);
        chk("arst_match",     32'(bus_a.match), 0);
        chk("arst_winner",    32'(bus_a.winner), 0);
        chk("arst_game_over", 32'(bus_a.game_over), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game sequencer sitting directly upstream of the win checker.
- Owns whose turn it is (T) and issues the one-cycle move pulse (B) when a picked card matches the tile ahead of the current player.
- Holds each reveal for a fixed time, passes the turn on a mismatch, and samples W after every move to freeze the game on a win.

Parameters:
- NUM_PLAYERS, 3, active players (2..3); T cycles 1..NUM_PLAYERS.
- PAT_W, 4, width of card/tile pattern codes.
- REVEAL_CYCLES, 50_000_000, clock cycles a revealed card is held before resolving (must be >= 1).
- TIMER_W, 26, reveal timer width; must hold REVEAL_CYCLES-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a game from IDLE.
- pick_valid  in  1  one-cycle pulse; the current player has chosen a card.
- card_pattern  in  PAT_W  pattern of the chosen card; valid with pick_valid.
- tile_pattern  in  PAT_W  pattern of the tile ahead of the current player; supplied by the board ROM, addressed from the win checker's position output.
- W  in  1  win flag from the win checker (combinational from the position counters).
- T  out  2  current player: 0 = none, 1..NUM_PLAYERS = active player.
- B  out  1  move pulse to the win checker; exactly one cycle per match.
- reveal  out  1  high while a picked card is shown (drives the card LED/display).
- match  out  1  registered result of the last comparison; valid while reveal = 1.
- streak  out  4  consecutive matches in the current turn; saturates at 15.
- game_over  out  1  high once a win is detected.
- winner  out  2  player number that won; 0 until game_over.

Behaviour:
- Reset (async, any state) sets all outputs to 0, timer to 0, and state to IDLE.
- States: IDLE, WAIT_PICK, REVEAL, MOVE, CHECK, NEXT, OVER. All outputs are registered.
- IDLE:
  - T = 0.
  - On start: T <= 1, streak <= 0, go to WAIT_PICK.
  - pick_valid is ignored.
- WAIT_PICK:
  - On pick_valid: match <= (card_pattern == tile_pattern), timer <= REVEAL_CYCLES-1, reveal <= 1, go to REVEAL.
  - tile_pattern is sampled on the same edge as card_pattern.
- REVEAL:
  - Timer decrements each cycle.
  - In the cycle the timer reads 0: reveal <= 0; go to MOVE if match, else NEXT.
  - Reveal lasts exactly REVEAL_CYCLES cycles.
- MOVE:
  - B = 1 for this single cycle.
  - streak <= min(streak+1, 15).
  - Go to CHECK.
- CHECK:
  - One cycle after the B pulse, so the counter update is visible on W.
  - If W: winner <= T, game_over <= 1, go to OVER.
  - Else go to WAIT_PICK; the same player keeps the turn.
- NEXT:
  - T <= (T == NUM_PLAYERS) ? 1 : T+1; streak <= 0.
  - Go to WAIT_PICK.
- OVER:
  - Terminal; T, winner and game_over hold.
  - start and pick_valid are ignored.
  - Only rst leaves OVER.
- Simultaneous or boundary events:
  - pick_valid outside WAIT_PICK is dropped and not queued.
  - start outside IDLE is ignored.
  - start and pick_valid in the same IDLE cycle: only start acts.
- Latency:
  - pick_valid to B is REVEAL_CYCLES+1 cycles on a match.
  - pick_valid to T change is REVEAL_CYCLES+1 cycles on a mismatch.
- B never asserts in consecutive cycles; the minimum spacing between B pulses is REVEAL_CYCLES+3.
- T never equals 0 outside IDLE, and never exceeds NUM_PLAYERS.

Decomposition:
- Shared package (game_pkg):
  - State encoding constants.
  - Player codes P_NONE=0, P1=1, P2=2, P3=3.
  - PAT_W default.
- Sub-module reveal_timer (load, count-down, zero flag), width TIMER_W. It is reused by the card-display stage.

Test Plan:
- Start sequence: REVEAL_CYCLES=4, rst then start -> T=1, B=0, reveal=0, game_over=0.
- Match path: pick_valid with card=5, tile=5 ->
  - reveal high exactly 4 cycles;
  - B=1 for one cycle, 5 cycles after pick;
  - streak=1, T stays 1.
- Mismatch path: pick card=5, tile=3 ->
  - no B pulse;
  - T goes 1->2 five cycles after pick, streak=0.
- Wrap: mismatches by players 1, 2 and 3 -> T sequence 1,2,3,1. With NUM_PLAYERS=2 -> T sequence 1,2,1.
- Win: W driven high when B pulses for player 2 ->
  - in the CHECK cycle, winner=2 and game_over=1;
  - further start/pick_valid pulses leave T, B and winner unchanged.
- Robustness:
  - pick_valid during REVEAL is ignored, with no second reveal and unchanged timing.
  - rst asserted mid-REVEAL gives all outputs 0 immediately, without waiting for a clock edge.
